// File: rtl/icache_pkg.sv
// Shared widths and types for the L1 instruction cache.
// Block address is {PPN, set index}.
package core_types_pkg;

   localparam int PPN_WIDTH                       = 22;
   localparam int ICACHE_NUM_SETS                 = 128;
   localparam int ICACHE_INDEX_WIDTH              = 7;
   localparam int ICACHE_BLOCK_SIZE               = 32;
   localparam int ICACHE_FETCH_WIDTH              = 16;
   localparam int ICACHE_FETCH_BLOCK_OFFSET_WIDTH = 1;
   localparam int ICACHE_TAG_WIDTH                = PPN_WIDTH;
   localparam int ICACHE_BLOCK_ADDR_WIDTH         = PPN_WIDTH + ICACHE_INDEX_WIDTH;

   typedef logic [ICACHE_TAG_WIDTH-1:0]                icache_tag_t;
   typedef logic [ICACHE_INDEX_WIDTH-1:0]              icache_index_t;
   typedef logic [ICACHE_FETCH_BLOCK_OFFSET_WIDTH-1:0] icache_offset_t;
   typedef logic [ICACHE_BLOCK_ADDR_WIDTH-1:0]         icache_pa_block_t;
   typedef logic [ICACHE_FETCH_WIDTH*8-1:0]            icache_fetch_t;
   typedef logic [ICACHE_BLOCK_SIZE*8-1:0]             icache_block_t;

   typedef enum logic [1:0] {
      MISS_IDLE,
      MISS_REQ,
      MISS_WAIT,
      MISS_FILL
   } icache_miss_state_t;

endpackage

// File: rtl/icache_if.sv
// Fetch-side and L2-side bundle of the instruction cache.
// slave = cache, master = frontend plus L2.
interface icache_if;
   import core_types_pkg::*;

   logic                   req_valid;
   icache_offset_t         req_block_offset;
   icache_index_t          req_index;
   logic [1:0]             resp_valid_by_way;
   icache_tag_t [1:0]      resp_tag_by_way;
   icache_fetch_t [1:0]    resp_instr_16B_by_way;
   logic                   resp_notif_valid;
   logic                   resp_notif_miss;
   logic [1:0]             resp_notif_way;
   icache_tag_t            resp_notif_tag;
   logic                   l2_req_valid;
   logic                   l2_req_ready;
   icache_pa_block_t       l2_req_PA_block;
   logic                   l2_resp_valid;
   icache_pa_block_t       l2_resp_PA_block;
   icache_block_t          l2_resp_data;
   logic                   inv_valid;
   logic                   miss_busy;

   modport slave (
      input  req_valid, req_block_offset, req_index,
      output resp_valid_by_way, resp_tag_by_way, resp_instr_16B_by_way,
      input  resp_notif_valid, resp_notif_miss, resp_notif_way, resp_notif_tag,
      output l2_req_valid, l2_req_PA_block,
      input  l2_req_ready, l2_resp_valid, l2_resp_PA_block, l2_resp_data,
      input  inv_valid,
      output miss_busy
   );

   modport master (
      output req_valid, req_block_offset, req_index,
      input  resp_valid_by_way, resp_tag_by_way, resp_instr_16B_by_way,
      output resp_notif_valid, resp_notif_miss, resp_notif_way, resp_notif_tag,
      input  l2_req_valid, l2_req_PA_block,
      output l2_req_ready, l2_resp_valid, l2_resp_PA_block, l2_resp_data,
      output inv_valid,
      input  miss_busy
   );

endinterface

// File: rtl/icache_way_array.sv
// One way of tag/data storage: synchronous read, single write port.
// A read and write to the same set in one cycle returns the old contents.
module icache_way_array
   import core_types_pkg::*;
(
   input  logic           clk,
   input  logic           rst_n,
   input  logic           rd_en,
   input  icache_index_t  rd_index,
   input  icache_offset_t rd_offset,
   output icache_tag_t    rd_tag,
   output icache_fetch_t  rd_data,
   input  logic           wr_en,
   input  icache_index_t  wr_index,
   input  icache_tag_t    wr_tag,
   input  icache_block_t  wr_data
);

   localparam int FW = ICACHE_FETCH_WIDTH * 8;

   icache_tag_t   tag_mem  [ICACHE_NUM_SETS];
   icache_block_t data_mem [ICACHE_NUM_SETS];
   icache_block_t rd_block;

   assign rd_block = data_mem[rd_index];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         tag_mem[wr_index]  <= wr_tag;
         data_mem[wr_index] <= wr_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_tag  <= '0;
         rd_data <= '0;
      end else if (rd_en) begin
         rd_tag  <= tag_mem[rd_index];
         rd_data <= rd_offset[0] ? rd_block[FW +: FW] : rd_block[0 +: FW];
      end
   end

endmodule

// File: rtl/icache.sv
// 2-way VIPT L1 instruction cache: array read, LRU, and L2 miss/fill FSM.
// Valid bits and LRU live here; tag/data live in the way arrays.
module icache
   import core_types_pkg::*;
(
   input logic     CLK,
   input logic     nRST,
   icache_if.slave bus
);

   icache_miss_state_t state_q, state_d;

   logic [1:0][ICACHE_NUM_SETS-1:0] valid_q;
   logic [ICACHE_NUM_SETS-1:0]      lru_q;
   icache_index_t                   idx_q;
   icache_pa_block_t                miss_pa_q;
   icache_block_t                   fill_data_q;
   logic                            squash_q;
   logic [1:0]                      resp_valid_q;

   icache_index_t       fill_set;
   icache_tag_t         fill_tag;
   logic                victim;
   logic                fill_we;
   logic                req_out;
   logic                hit_ok;
   logic                miss_ok;
   logic                resp_match;
   logic [1:0]          way_we;
   icache_tag_t [1:0]   way_tag;
   icache_fetch_t [1:0] way_data;

   assign fill_set   = miss_pa_q[ICACHE_INDEX_WIDTH-1:0];
   assign fill_tag   = miss_pa_q[ICACHE_BLOCK_ADDR_WIDTH-1:ICACHE_INDEX_WIDTH];
   assign hit_ok     = bus.resp_notif_valid && !bus.resp_notif_miss
                       && (^bus.resp_notif_way);
   assign miss_ok    = bus.resp_notif_valid && bus.resp_notif_miss;
   assign resp_match = bus.l2_resp_valid
                       && (bus.l2_resp_PA_block == miss_pa_q);

   // Prefer an empty way before consulting LRU
   always_comb begin
      if (!valid_q[0][fill_set])      victim = 1'b0;
      else if (!valid_q[1][fill_set]) victim = 1'b1;
      else                            victim = lru_q[fill_set];
   end

   always_comb begin
      state_d = state_q;
      req_out = 1'b0;
      fill_we = 1'b0;
      unique case (state_q)
         MISS_IDLE: if (miss_ok) state_d = MISS_REQ;
         MISS_REQ: begin
            req_out = 1'b1;
            if (bus.l2_req_ready) state_d = MISS_WAIT;
         end
         MISS_WAIT: if (resp_match) state_d = MISS_FILL;
         MISS_FILL: begin
            fill_we = !squash_q;
            state_d = MISS_IDLE;
         end
         default: state_d = MISS_IDLE;
      endcase
   end

   assign way_we = !fill_we ? 2'b00 : (victim ? 2'b10 : 2'b01);

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q      <= MISS_IDLE;
         valid_q      <= '0;
         lru_q        <= '0;
         idx_q        <= '0;
         miss_pa_q    <= '0;
         fill_data_q  <= '0;
         squash_q     <= 1'b0;
         resp_valid_q <= '0;
      end else begin
         state_q <= state_d;
         if (bus.req_valid) begin
            idx_q        <= bus.req_index;
            resp_valid_q <= {valid_q[1][bus.req_index],
                             valid_q[0][bus.req_index]};
         end
         if (hit_ok)
            lru_q[idx_q] <= bus.resp_notif_way[0];
         if (state_q == MISS_IDLE && miss_ok)
            miss_pa_q <= {bus.resp_notif_tag, idx_q};
         if (state_q == MISS_WAIT && resp_match)
            fill_data_q <= bus.l2_resp_data;
         // Fill LRU update follows the hit update so it takes priority
         if (fill_we) begin
            valid_q[victim][fill_set] <= 1'b1;
            lru_q[fill_set]           <= ~victim;
         end
         if (bus.inv_valid)
            valid_q <= '0;
         if (state_q == MISS_FILL)
            squash_q <= 1'b0;
         else if (bus.inv_valid
                  && (state_q == MISS_REQ || state_q == MISS_WAIT))
            squash_q <= 1'b1;
      end
   end

   for (genvar w = 0; w < 2; w++) begin : g_way
      icache_way_array u_way (
         .clk       (CLK),
         .rst_n     (nRST),
         .rd_en     (bus.req_valid),
         .rd_index  (bus.req_index),
         .rd_offset (bus.req_block_offset),
         .rd_tag    (way_tag[w]),
         .rd_data   (way_data[w]),
         .wr_en     (way_we[w]),
         .wr_index  (fill_set),
         .wr_tag    (fill_tag),
         .wr_data   (fill_data_q)
      );
   end

   assign bus.resp_valid_by_way     = resp_valid_q;
   assign bus.resp_tag_by_way       = way_tag;
   assign bus.resp_instr_16B_by_way = way_data;
   assign bus.l2_req_valid          = req_out;
   assign bus.l2_req_PA_block       = miss_pa_q;
   assign bus.miss_busy             = (state_q != MISS_IDLE);

endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: cold miss, LRU, L2 stalls, invalidation,
// read/fill collision and reset mid-miss.
module tb_icache;
   import core_types_pkg::*;

   logic clk;
   logic nrst;
   int   checks;
   int   failures;

   icache_if bus ();

   icache dut (
      .CLK  (clk),
      .nRST (nrst),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [255:0] got,
                        input logic [255:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [255:0] blk(input logic [7:0] s);
      logic [255:0] b;
      for (int i = 0; i < 32; i++) b[i*8 +: 8] = s + 8'(i);
      return b;
   endfunction

   function automatic logic [127:0] half(input logic [255:0] b,
                                         input logic off);
      return off ? b[255:128] : b[127:0];
   endfunction

   function automatic logic [28:0] pa(input logic [21:0] t,
                                      input logic [6:0] i);
      return {t, i};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rd(input logic [6:0] idx, input logic off);
      bus.req_valid        = 1'b1;
      bus.req_index        = idx;
      bus.req_block_offset = off;
      tick();
      bus.req_valid = 1'b0;
   endtask

   task automatic notif_miss(input logic [21:0] t);
      bus.resp_notif_valid = 1'b1;
      bus.resp_notif_miss  = 1'b1;
      bus.resp_notif_tag   = t;
      tick();
      bus.resp_notif_valid = 1'b0;
      bus.resp_notif_miss  = 1'b0;
   endtask

   task automatic notif_hit(input logic [1:0] way);
      bus.resp_notif_valid = 1'b1;
      bus.resp_notif_miss  = 1'b0;
      bus.resp_notif_way   = way;
      tick();
      bus.resp_notif_valid = 1'b0;
   endtask

   task automatic l2_respond(input logic [28:0] a, input logic [255:0] d);
      bus.l2_resp_valid    = 1'b1;
      bus.l2_resp_PA_block = a;
      bus.l2_resp_data     = d;
      tick();
      bus.l2_resp_valid = 1'b0;
   endtask

   // Handshake the pending request and return data; ends in the FILL cycle
   task automatic serve(input logic [28:0] a, input logic [255:0] d);
      for (int i = 0; i < 20 && !bus.l2_req_valid; i++) tick();
      check("l2_req_seen", bus.l2_req_valid, 1);
      check("l2_req_pa", bus.l2_req_PA_block, a);
      bus.l2_req_ready = 1'b1;
      tick();
      bus.l2_req_ready = 1'b0;
      l2_respond(a, d);
   endtask

   task automatic fill(input logic [6:0] idx, input logic [21:0] t,
                       input logic [7:0] s);
      rd(idx, 1'b0);
      notif_miss(t);
      serve(pa(t, idx), blk(s));
      tick();
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      nrst     = 1'b0;
      bus.req_valid        = 1'b0;
      bus.req_block_offset = 1'b0;
      bus.req_index        = '0;
      bus.resp_notif_valid = 1'b0;
      bus.resp_notif_miss  = 1'b0;
      bus.resp_notif_way   = '0;
      bus.resp_notif_tag   = '0;
      bus.l2_req_ready     = 1'b0;
      bus.l2_resp_valid    = 1'b0;
      bus.l2_resp_PA_block = '0;
      bus.l2_resp_data     = '0;
      bus.inv_valid        = 1'b0;
      repeat (3) tick();
      nrst = 1'b1;
      tick();

      check("rst_valid", bus.resp_valid_by_way, 0);
      check("rst_tag", bus.resp_tag_by_way, 0);
      check("rst_instr", bus.resp_instr_16B_by_way, 0);
      check("rst_l2_req", bus.l2_req_valid, 0);
      check("rst_busy", bus.miss_busy, 0);

      // cold miss
      rd(7'd5, 1'b0);
      check("cold_valid", bus.resp_valid_by_way, 2'b00);
      notif_miss(22'h3ABCD);
      check("cold_busy", bus.miss_busy, 1);
      serve(pa(22'h3ABCD, 7'd5), blk(8'h10));
      tick();
      check("cold_idle", bus.miss_busy, 0);
      rd(7'd5, 1'b1);
      check("cold_fill_valid", bus.resp_valid_by_way, 2'b01);
      check("cold_fill_tag0", bus.resp_tag_by_way[0], 22'h3ABCD);
      check("cold_fill_data0", bus.resp_instr_16B_by_way[0],
            half(blk(8'h10), 1'b1));

      // LRU eviction in set 9
      fill(7'd9, 22'h0AAAA, 8'h20);
      fill(7'd9, 22'h0BBBB, 8'h40);
      rd(7'd9, 1'b0);
      check("lru_valid", bus.resp_valid_by_way, 2'b11);
      check("lru_tagA", bus.resp_tag_by_way[0], 22'h0AAAA);
      check("lru_tagB", bus.resp_tag_by_way[1], 22'h0BBBB);
      notif_hit(2'b01);
      notif_miss(22'h0CCCC);
      serve(pa(22'h0CCCC, 7'd9), blk(8'h60));
      tick();
      rd(7'd9, 1'b0);
      check("lru_evict_tag0", bus.resp_tag_by_way[0], 22'h0AAAA);
      check("lru_evict_tag1", bus.resp_tag_by_way[1], 22'h0CCCC);
      check("lru_evict_data1", bus.resp_instr_16B_by_way[1],
            half(blk(8'h60), 1'b0));
      notif_miss(22'h0DDDD);
      serve(pa(22'h0DDDD, 7'd9), blk(8'h80));
      tick();
      rd(7'd9, 1'b0);
      check("lru_after_fill_tag0", bus.resp_tag_by_way[0], 22'h0DDDD);
      check("lru_after_fill_tag1", bus.resp_tag_by_way[1], 22'h0CCCC);
      notif_hit(2'b00);
      notif_miss(22'h0EEEE);
      serve(pa(22'h0EEEE, 7'd9), blk(8'hA0));
      tick();
      rd(7'd9, 1'b0);
      check("bad_way_tag0", bus.resp_tag_by_way[0], 22'h0DDDD);
      check("bad_way_tag1", bus.resp_tag_by_way[1], 22'h0EEEE);

      // L2 backpressure and mismatched response
      rd(7'd20, 1'b0);
      notif_miss(22'h11111);
      for (int i = 0; i < 5; i++) begin
         check("bp_req_valid", bus.l2_req_valid, 1);
         check("bp_req_pa", bus.l2_req_PA_block, pa(22'h11111, 7'd20));
         tick();
      end
      bus.l2_req_ready = 1'b1;
      tick();
      bus.l2_req_ready = 1'b0;
      check("bp_req_dropped", bus.l2_req_valid, 0);
      l2_respond(pa(22'h11112, 7'd20), blk(8'hEE));
      tick();
      check("bp_wrong_resp_busy", bus.miss_busy, 1);
      l2_respond(pa(22'h11111, 7'd20), blk(8'h30));
      tick();
      rd(7'd20, 1'b1);
      check("bp_fill_valid", bus.resp_valid_by_way, 2'b01);
      check("bp_fill_tag0", bus.resp_tag_by_way[0], 22'h11111);
      check("bp_fill_data0", bus.resp_instr_16B_by_way[0],
            half(blk(8'h30), 1'b1));

      // second miss while busy is dropped
      rd(7'd30, 1'b0);
      notif_miss(22'h22222);
      bus.l2_req_ready = 1'b1;
      tick();
      bus.l2_req_ready = 1'b0;
      rd(7'd7, 1'b0);
      notif_miss(22'h33333);
      l2_respond(pa(22'h22222, 7'd30), blk(8'h50));
      tick();
      check("busy_miss_idle", bus.miss_busy, 0);
      for (int i = 0; i < 3; i++) begin
         check("busy_miss_no_req", bus.l2_req_valid, 0);
         tick();
      end
      rd(7'd30, 1'b0);
      check("busy_miss_set30", bus.resp_valid_by_way, 2'b01);
      rd(7'd7, 1'b0);
      check("busy_miss_set7", bus.resp_valid_by_way, 2'b00);

      // invalidate during WAIT, with a same-cycle read of set 9
      rd(7'd40, 1'b0);
      notif_miss(22'h04444);
      bus.l2_req_ready = 1'b1;
      tick();
      bus.l2_req_ready = 1'b0;
      bus.inv_valid = 1'b1;
      rd(7'd9, 1'b0);
      bus.inv_valid = 1'b0;
      check("inv_pre_valid", bus.resp_valid_by_way, 2'b11);
      l2_respond(pa(22'h04444, 7'd40), blk(8'h70));
      tick();
      check("inv_idle", bus.miss_busy, 0);
      rd(7'd40, 1'b0);
      check("inv_set40", bus.resp_valid_by_way, 2'b00);
      rd(7'd5, 1'b0);
      check("inv_set5", bus.resp_valid_by_way, 2'b00);
      rd(7'd9, 1'b0);
      check("inv_set9", bus.resp_valid_by_way, 2'b00);

      // read in the FILL cycle sees pre-fill contents
      fill(7'd50, 22'h05050, 8'h11);
      fill(7'd50, 22'h15151, 8'h33);
      rd(7'd50, 1'b0);
      notif_hit(2'b10);
      notif_miss(22'h25252);
      serve(pa(22'h25252, 7'd50), blk(8'h55));
      rd(7'd50, 1'b0);
      check("coll_pre_valid", bus.resp_valid_by_way, 2'b11);
      check("coll_pre_tag0", bus.resp_tag_by_way[0], 22'h05050);
      check("coll_pre_data0", bus.resp_instr_16B_by_way[0],
            half(blk(8'h11), 1'b0));
      rd(7'd50, 1'b0);
      check("coll_post_tag0", bus.resp_tag_by_way[0], 22'h25252);
      check("coll_post_data0", bus.resp_instr_16B_by_way[0],
            half(blk(8'h55), 1'b0));
      check("coll_post_tag1", bus.resp_tag_by_way[1], 22'h15151);

      // asynchronous reset while waiting on L2
      rd(7'd60, 1'b0);
      notif_miss(22'h06666);
      bus.l2_req_ready = 1'b1;
      tick();
      bus.l2_req_ready = 1'b0;
      rd(7'd50, 1'b0);
      check("arst_pre_valid", bus.resp_valid_by_way, 2'b11);
      #3;
      nrst = 1'b0;
      #1;
      check("arst_busy", bus.miss_busy, 0);
      check("arst_l2_req", bus.l2_req_valid, 0);
      check("arst_resp_valid", bus.resp_valid_by_way, 2'b00);
      tick();
      nrst = 1'b1;
      l2_respond(pa(22'h06666, 7'd60), blk(8'h99));
      tick();
      check("arst_late_busy", bus.miss_busy, 0);
      rd(7'd60, 1'b0);
      check("arst_set60", bus.resp_valid_by_way, 2'b00);
      rd(7'd50, 1'b0);
      check("arst_set50", bus.resp_valid_by_way, 2'b00);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/icache.md
Name: icache

Overview:
- 2-way set-associative, virtually-indexed / physically-tagged L1 instruction cache.
- Responder for the fetch-side icache interface:
  - accepts the index and fetch-block-offset request in the fetch req stage;
  - returns both ways' tags and 16B data one cycle later;
  - consumes the hit/miss notification that the fetch resp stage produces after its own tag compare.
- On a miss it fetches the block from L2 and fills the LRU way.

Parameters:
- ICACHE_NUM_SETS, 128, number of sets; ICACHE_INDEX_WIDTH = log2 = 7.
- ICACHE_BLOCK_SIZE, 32, bytes per block.
- ICACHE_FETCH_WIDTH, 16, bytes per fetch; ICACHE_FETCH_BLOCK_OFFSET_WIDTH = 1.
- ICACHE_TAG_WIDTH, 22, tag width, equal to PPN_WIDTH (index + block offset = 12-bit page offset).

Ports:
- CLK  in  1  clock
- nRST  in  1  asynchronous active-low reset
- req_valid  in  1  fetch read request
- req_block_offset  in  1  16B half of block
- req_index  in  7  set index
- resp_valid_by_way  out  2  way valid bits of set read last cycle
- resp_tag_by_way  out  2x22  way tags
- resp_instr_16B_by_way  out  2x16x8  way fetch data
- resp_notif_valid  in  1  fetch resp stage outcome valid
- resp_notif_miss  in  1  1 = miss in both ways
- resp_notif_way  in  2  one-hot hit way (when miss=0)
- resp_notif_tag  in  22  PPN of access (miss tag)
- l2_req_valid  out  1  block read to L2
- l2_req_ready  in  1  L2 accepts
- l2_req_PA_block  out  29  {tag, index}
- l2_resp_valid  in  1  L2 block returned
- l2_resp_PA_block  in  29  returned block address
- l2_resp_data  in  32x8  block data
- inv_valid  in  1  flush all (fence.i)
- miss_busy  out  1  miss FSM not IDLE

Behaviour:
- Arrays per way: valid[128], tag[128], data[128][32B]. lru[128] holds 1 bit, the way to evict next. Register idx_q holds the index of the last accepted req.
- Read:
  - req_valid in cycle N → resp_* driven in cycle N+1 from registered outputs.
  - Without req_valid, outputs hold their last values. The frontend ignores them.
- Notif arrives in any cycle ≥ N+1 and applies to idx_q.
  - Hit: lru[idx_q] <= way not in notif_way. A notif_way that is not one-hot is ignored.
  - Miss while IDLE: latch miss_PA = {notif_tag, idx_q} and go to REQ.
  - Miss while not IDLE: ignored; the frontend re-requests.
- Miss FSM states IDLE, REQ, WAIT, FILL:
  - REQ: l2_req_valid = 1, l2_req_PA_block = miss_PA. Go to WAIT on l2_req_ready.
  - WAIT: on l2_resp_valid with l2_resp_PA_block == miss_PA, capture data and go to FILL. A non-matching response is dropped.
  - FILL (1 cycle):
    - victim = way0 if invalid, else way1 if invalid, else lru[set];
    - write tag, data and valid = 1 to the victim;
    - lru[set] <= other way;
    - return to IDLE.
- Same-cycle read and fill to the same set: the read returns pre-fill contents (read-before-write).
- Same-cycle hit notif and fill to the same set: the fill's LRU update wins.
- inv_valid clears all valid bits at the next edge.
  - If the FSM is in REQ or WAIT, set squash. When the response arrives, FILL writes nothing and squash clears.
  - inv_valid in the FILL cycle: invalidation wins, and the fill's valid bit is not set.
  - A read in the same cycle as inv_valid returns pre-invalidate valids.
- miss_busy = (state != IDLE).
- Reset (asynchronous): state IDLE; all valid = 0; lru = 0; squash = 0; resp_valid_by_way = 0; resp_tag / resp_instr = 0; l2_req_valid = 0; idx_q = 0.
  - Tag and data arrays are not reset.
  - Reset mid-miss abandons the request. A stale L2 response after reset is dropped because the FSM is IDLE.
- Miss latency (cycles from notif to fill visible):
  - 1 cycle to REQ;
  - plus the L2 handshake;
  - plus 1 cycle of FILL;
  - plus 1 cycle before a read reflects the fill.

Decomposition:
- core_types_pkg: ICACHE_* widths, icache_miss_state_t enum, block address width (PPN_WIDTH + ICACHE_INDEX_WIDTH).
- One natural sub-module: icache_way_array, one instance per way. It holds tag/data storage with a synchronous read port and one write port, and implements the read-before-write rule. Valid bits and LRU stay in the top level.

Test Plan:
- Cold miss: reset, req idx 5 off 0 → resp_valid_by_way = 00 next cycle. Then notif miss, tag 0x3ABCD → l2_req_PA_block = {0x3ABCD, 5}. Respond with data pattern → way0 filled. Re-req idx 5 off 1 → valid = 01, tag0 = 0x3ABCD, data = bytes 16-31.
- LRU eviction:
  - Fill idx 9 way0 (tag A) and way1 (tag B), then hit notif on way0.
  - Miss tag C → way1 replaced. Resp shows tags {A, C}.
  - lru[9] = 0 after the fill.
- L2 backpressure / mismatch: hold l2_req_ready = 0 for 5 cycles → l2_req_valid stays high and stable. Then a response with a wrong PA_block is ignored, and the matching response completes the fill.
- Notif miss while busy: during WAIT, a second miss notif for idx 7 → no new l2_req after the fill. FSM returns to IDLE and miss_busy = 0.
- inv during WAIT: inv_valid then L2 response → no way valid at that set, and all sets read valid = 00.
- Read/fill collision: req to the fill set in the FILL cycle → pre-fill data. Next req → new data.
- Async reset mid-miss: nRST low in WAIT → l2_req_valid = 0 and valids cleared immediately. A late L2 response causes no write.
